// File: rtl/serial_word_receiver_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// serial_word_receiver_pkg : FSM states and serial line levels. Rev 1.0
// ------------------------------------------------------------------
package serial_word_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    STOP  = 2'd2,
    BREAK = 2'd3
  } state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // A single-bit word still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_word_receiver_if.sv
`default_nettype none
// ------------------------------------------------------------------
// serial_word_receiver_if : received-word stream with status pulses. Rev 1.0
// ------------------------------------------------------------------
interface serial_word_receiver_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] Data;
  logic             Valid;
  logic             Ready;
  logic             Overrun;
  logic             FrameError;

  modport master (
    output Data,
    output Valid,
    input  Ready,
    output Overrun,
    output FrameError
  );

  modport slave (
    input  Data,
    input  Valid,
    output Ready,
    input  Overrun,
    input  FrameError
  );
endinterface
`default_nettype wire

// File: rtl/serial_shift_in.sv
`default_nettype none
// ------------------------------------------------------------------
// serial_shift_in : LSB-first shift register and data-bit counter. Rev 1.0
// ------------------------------------------------------------------
module serial_shift_in
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic             i_Clock,
  input  wire logic             i_Reset,
  input  wire logic             i_Clear,
  input  wire logic             i_Shift,
  input  wire logic             i_Bit,
  output      logic [WIDTH-1:0] o_Word,
  output      logic             o_Last
);

  localparam int            CW          = cnt_width(WIDTH);
  localparam logic [CW-1:0] c_LastCount = CW'(WIDTH - 1);

  logic [CW-1:0]    r_Count;
  logic [WIDTH-1:0] r_Word;
  logic [WIDTH-1:0] w_Shifted;

  // New bits enter at the MSB so the first received bit lands in bit 0.
  generate
    if (WIDTH == 1) begin : g_single
      assign w_Shifted = i_Bit;
    end else begin : g_multi
      assign w_Shifted = {i_Bit, r_Word[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Count <= '0;
      r_Word  <= '0;
    end else begin
      if (i_Clear) begin
        r_Count <= '0;
      end else if (i_Shift) begin
        r_Count <= (r_Count == c_LastCount) ? '0 : r_Count + 1'b1;
      end
      if (i_Shift) begin
        r_Word <= w_Shifted;
      end
    end
  end

  assign o_Word = r_Word;
  assign o_Last = (r_Count == c_LastCount);

endmodule
`default_nettype wire

// File: rtl/serial_word_receiver.sv
`default_nettype none
// ------------------------------------------------------------------
// serial_word_receiver : start/data/stop frame to valid/ready word. Rev 1.0
// ------------------------------------------------------------------
module serial_word_receiver
  import serial_word_receiver_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  wire logic                   i_Clock,
  input  wire logic                   i_Reset,
  input  wire logic                   i_Serial,
  serial_word_receiver_if.master      o_Stream
);

  state_t           r_State;
  state_t           w_NextState;
  logic             w_Clear;
  logic             w_Shift;
  logic             w_Complete;
  logic             w_StopError;
  logic             w_Last;
  logic [WIDTH-1:0] w_Word;

  logic [WIDTH-1:0] r_Data;
  logic             r_Valid;
  logic             r_Overrun;
  logic             r_FrameError;

  serial_shift_in #(
    .WIDTH (WIDTH)
  ) u_shift_in (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Clear (w_Clear),
    .i_Shift (w_Shift),
    .i_Bit   (i_Serial),
    .o_Word  (w_Word),
    .o_Last  (w_Last)
  );

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  always_comb begin
    w_NextState = r_State;
    w_Clear     = 1'b0;
    w_Shift     = 1'b0;
    w_Complete  = 1'b0;
    w_StopError = 1'b0;
    case (r_State)
      IDLE: begin
        if (i_Serial == START_BIT) begin
          w_NextState = DATA;
          w_Clear     = 1'b1;
        end
      end
      DATA: begin
        w_Shift = 1'b1;
        if (w_Last) begin
          w_NextState = STOP;
        end
      end
      STOP: begin
        if (i_Serial == STOP_BIT) begin
          w_Complete  = 1'b1;
          w_NextState = IDLE;
        end else begin
          w_StopError = 1'b1;
          w_NextState = BREAK;
        end
      end
      BREAK: begin
        // A held-low line must return high before another start is honoured.
        if (i_Serial == IDLE_LEVEL) begin
          w_NextState = IDLE;
        end
      end
      default: begin
        w_NextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Data       <= '0;
      r_Valid      <= 1'b0;
      r_Overrun    <= 1'b0;
      r_FrameError <= 1'b0;
    end else begin
      r_Overrun    <= 1'b0;
      r_FrameError <= w_StopError;
      if (w_Complete) begin
        // A word consumed this cycle frees the slot for the new one.
        if (!r_Valid || o_Stream.Ready) begin
          r_Data  <= w_Word;
          r_Valid <= 1'b1;
        end else begin
          r_Overrun <= 1'b1;
        end
      end else if (r_Valid && o_Stream.Ready) begin
        r_Valid <= 1'b0;
      end
    end
  end

  assign o_Stream.Data       = r_Data;
  assign o_Stream.Valid      = r_Valid;
  assign o_Stream.Overrun    = r_Overrun;
  assign o_Stream.FrameError = r_FrameError;

endmodule
`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_serial_word_receiver : scoreboard bench for serial_word_receiver. Rev 1.0
// ------------------------------------------------------------------
module tb_serial_word_receiver;
  import serial_word_receiver_pkg::*;

  localparam int WIDTH = 4;

  logic i_Clock  = 1'b0;
  logic i_Reset  = 1'b1;
  logic r_Serial = IDLE_LEVEL;

  int n_total = 0;
  int n_bad   = 0;
  int n_ovr_seen = 0;
  int n_fe_seen  = 0;
  int n_ovr_exp  = 0;
  int n_fe_exp   = 0;
  logic [WIDTH-1:0] q_exp[$];

  serial_word_receiver_if #(.WIDTH(WIDTH)) u_if ();

  serial_word_receiver #(
    .WIDTH (WIDTH)
  ) u_dut (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Serial (r_Serial),
    .o_Stream (u_if)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit; returns just after the edge that sampled it.
  task automatic drive_bit(input logic b);
    r_Serial = b;
    @(posedge i_Clock);
    #1;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input logic stop, input logic rdy_at_stop);
    drive_bit(START_BIT);
    for (int i = 0; i < WIDTH; i++) drive_bit(w[i]);
    if (rdy_at_stop) u_if.Ready = 1'b1;
    drive_bit(stop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_bit(IDLE_LEVEL);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_queue_left"}, 32'(q_exp.size()), 32'd0);
    check({tag, "_overrun_cnt"}, 32'(n_ovr_seen), 32'(n_ovr_exp));
    check({tag, "_frameerr_cnt"}, 32'(n_fe_seen), 32'(n_fe_exp));
  endtask

  always @(negedge i_Clock) begin
    if (!i_Reset) begin
      if (u_if.Valid && u_if.Ready) begin
        if (q_exp.size() == 0) check("sb_unexpected_word", 32'(q_exp.size()), 32'd1);
        else check("sb_word", 32'(u_if.Data), 32'(q_exp.pop_front()));
      end
      if (u_if.Overrun) n_ovr_seen++;
      if (u_if.FrameError) n_fe_seen++;
      if (u_if.Overrun && u_if.FrameError) check("flags_exclusive", 32'd1, 32'(1'b0));
    end
  end

  initial begin
    logic [WIDTH-1:0] w_d;
    u_if.Ready = 1'b0;
    r_Serial   = IDLE_LEVEL;
    i_Reset    = 1'b1;
    repeat (3) @(posedge i_Clock);
    #1;
    @(negedge i_Clock);
    check("rst_data", 32'(u_if.Data), 32'd0);
    check("rst_valid", 32'(u_if.Valid), 32'd0);
    check("rst_overrun", 32'(u_if.Overrun), 32'd0);
    check("rst_frameerr", 32'(u_if.FrameError), 32'd0);
    @(posedge i_Clock);
    #1;
    i_Reset = 1'b0;

    // Single frame 4'hD with exact output timing.
    u_if.Ready = 1'b1;
    idle(2);
    w_d = 4'hD;
    q_exp.push_back(w_d);
    drive_bit(START_BIT);
    for (int i = 0; i < WIDTH; i++) drive_bit(w_d[i]);
    r_Serial = STOP_BIT;
    @(negedge i_Clock);
    check("t1_valid_at_stop", 32'(u_if.Valid), 32'd0);
    @(posedge i_Clock);
    #1;
    @(negedge i_Clock);
    check("t1_valid", 32'(u_if.Valid), 32'd1);
    check("t1_data", 32'(u_if.Data), 32'hD);
    @(posedge i_Clock);
    #1;
    @(negedge i_Clock);
    check("t1_valid_after", 32'(u_if.Valid), 32'd0);
    idle(2);
    check_counts("t1");

    // Held output while not ready.
    u_if.Ready = 1'b0;
    q_exp.push_back(4'hD);
    send_frame(4'hD, STOP_BIT, 1'b0);
    r_Serial = IDLE_LEVEL;
    repeat (20) begin
      @(negedge i_Clock);
      check("t2_hold_valid", 32'(u_if.Valid), 32'd1);
      check("t2_hold_data", 32'(u_if.Data), 32'hD);
    end
    @(posedge i_Clock);
    #1;
    u_if.Ready = 1'b1;
    @(posedge i_Clock);
    #1;
    u_if.Ready = 1'b0;
    @(negedge i_Clock);
    check("t2_valid_dropped", 32'(u_if.Valid), 32'd0);
    idle(2);
    check_counts("t2");

    // Overrun: 4'hA dropped while 4'h3 is held.
    q_exp.push_back(4'h3);
    send_frame(4'h3, STOP_BIT, 1'b0);
    send_frame(4'hA, STOP_BIT, 1'b0);
    n_ovr_exp++;
    idle(1);
    @(negedge i_Clock);
    check("t3_kept_data", 32'(u_if.Data), 32'h3);
    check("t3_kept_valid", 32'(u_if.Valid), 32'd1);
    @(posedge i_Clock);
    #1;
    u_if.Ready = 1'b1;
    idle(1);
    u_if.Ready = 1'b0;
    idle(2);
    check_counts("t3a");

    // Completion and consumption in the same cycle.
    q_exp.push_back(4'h3);
    q_exp.push_back(4'hA);
    send_frame(4'h3, STOP_BIT, 1'b0);
    send_frame(4'hA, STOP_BIT, 1'b1);
    @(negedge i_Clock);
    check("t3b_new_data", 32'(u_if.Data), 32'hA);
    check("t3b_new_valid", 32'(u_if.Valid), 32'd1);
    idle(3);
    check_counts("t3b");

    // Framing error, held-low break, then recovery.
    send_frame(4'h5, 1'b0, 1'b0);
    n_fe_exp++;
    for (int i = 0; i < 9; i++) drive_bit(1'b0);
    idle(2);
    q_exp.push_back(4'h9);
    send_frame(4'h9, STOP_BIT, 1'b0);
    idle(2);
    check_counts("t4");

    // Reset in the middle of frame 4'hF.
    drive_bit(START_BIT);
    drive_bit(1'b1);
    drive_bit(1'b1);
    i_Reset = 1'b1;
    drive_bit(1'b1);
    i_Reset = 1'b0;
    @(negedge i_Clock);
    check("t5_rst_data", 32'(u_if.Data), 32'd0);
    check("t5_rst_valid", 32'(u_if.Valid), 32'd0);
    check("t5_rst_overrun", 32'(u_if.Overrun), 32'd0);
    check("t5_rst_frameerr", 32'(u_if.FrameError), 32'd0);
    idle(3);
    q_exp.push_back(4'h6);
    send_frame(4'h6, STOP_BIT, 1'b0);
    idle(2);
    check_counts("t5");

    // Streaming at the minimum frame period.
    for (int v = 0; v < 16; v++) begin
      q_exp.push_back(WIDTH'(v));
      send_frame(WIDTH'(v), STOP_BIT, 1'b0);
    end
    idle(3);
    check_counts("t6");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Receive-side counterpart to the registered input-reduction test designs: takes a single serial pin and expands it back into a parallel WIDTH-bit word.
- Frame format: start bit 0, WIDTH data bits LSB first, stop bit 1. One bit is sampled per i_Clock, with no oversampling.
- Received words are presented on a valid/ready output with overrun and framing-error flags.
- Serves as a sequential test design for the fabric: FSM, counter, shift register and handshake.

Parameters:
- WIDTH, 4, data bits per frame; legal range 1..16.

Ports:
- i_Clock  in  1  clock, all logic on the rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Serial  in  1  serial line; idles high.
- o_Data  out  WIDTH  received word; stable while o_Valid=1.
- o_Valid  out  1  word available.
- i_Ready  in  1  consumer accepts o_Data when o_Valid&&i_Ready.
- o_Overrun  out  1  one-cycle pulse: a completed word was dropped.
- o_FrameError  out  1  one-cycle pulse: stop bit sampled as 0.

Behaviour:
- Reset: i_Reset, synchronous, active-high; clock i_Clock.
  - Reset outputs: o_Data=0, o_Valid=0, o_Overrun=0, o_FrameError=0.
  - Reset internals: state=IDLE, bit counter=0, shift register=0.
  - Reset takes priority over everything, including a frame in progress; the partial frame is discarded with no flags.
- States:
  - IDLE: i_Serial=0 sampled -> DATA, counter=0; otherwise stay.
  - DATA: shift i_Serial into the MSB, shifting right, so the first data bit ends in bit 0. Counter increments each cycle; at counter=WIDTH-1 -> STOP.
  - STOP, i_Serial=1: word complete -> IDLE.
  - STOP, i_Serial=0: o_FrameError=1 next cycle, word discarded -> BREAK.
  - BREAK: wait for i_Serial=1 -> IDLE. A line held low never starts a new frame.
- Timing: start bit sampled at cycle t; data at t+1..t+WIDTH; stop at t+WIDTH+1; o_Valid/o_Data updated at t+WIDTH+2.
- Back-to-back frames: IDLE accepts a new start bit the cycle after STOP, giving a minimum frame period of WIDTH+2 cycles.
- Handshake:
  - o_Valid stays high, with o_Data held, until o_Valid&&i_Ready.
  - Transfer cycle with no new completion: o_Valid=0 next cycle.
- Completion and consumption in the same cycle (o_Valid&&i_Ready): load the new word, o_Valid stays 1, no overrun.
- Completion while o_Valid=1 and i_Ready=0: the new word is dropped, the old word is kept, o_Overrun=1 for one cycle.
- Framing error while o_Valid=1: the held word is unaffected.
- Flags are registered pulses, exactly one cycle wide, and never asserted simultaneously.
- Counter width is $clog2(WIDTH), minimum 1 bit. WIDTH=1 goes DATA -> STOP after one bit.

Decomposition:
- Package serial_word_receiver_pkg:
  - state enum {IDLE, DATA, STOP, BREAK}.
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- One sub-module, serial_shift_in, owns the shift register and bit counter.
  - Inputs: i_Clock, i_Reset, i_Clear, i_Shift, i_Bit.
  - Outputs: o_Word, o_Last.
- Top level holds the FSM, output register and flags.

Test Plan:
- Single frame, WIDTH=4, i_Ready=1: i_Serial=1,1,0,1,0,1,1,1 from cycle 0 (start bit at cycle 2) -> o_Data=4'hD with o_Valid=1 at cycle 8 only; no flags.
- Held output: the same frame with i_Ready=0 -> o_Valid stays 1 and o_Data=4'hD for 20 cycles. Raising i_Ready for one cycle -> o_Valid=0 on the next cycle.
- Overrun, then simultaneous consumption:
  - Frame 4'h3 not consumed, then back-to-back frame 4'hA -> o_Overrun pulse; o_Data remains 4'h3.
  - Repeat with i_Ready=1 on the completion cycle of 4'hA -> o_Data=4'hA, o_Valid stays 1, no overrun.
- Framing error: start, data 4'h5, stop=0, line held low for 10 cycles, then high, then frame 4'h9.
  - Required: o_FrameError pulses once, no o_Valid for 4'h5, no frame starts during the low period.
  - 4'h9 is then received correctly.
- Reset mid-frame: assert i_Reset for 1 cycle during the data bits of frame 4'hF.
  - Required: all outputs 0 the next cycle, no flags.
  - A following frame 4'h6 is received correctly.
- Streaming: 16 back-to-back frames 0..15 at the minimum period (6 cycles) with i_Ready=1 -> 16 valid words in order, no flags.
